// File: rtl/amp_arb.sv
// amp_arb: round-robin arbiter time-sharing one thermometer encoder among N_CH sources.
// Define AMP_ARB_PRIO_EN to give channel 0 strict priority over the rotation.
module amp_arb #(
    parameter int N_CH = 4,
    parameter int CHW  = 2
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   req_valid,
    input  logic [N_CH*8-1:0] req_data,
    output logic [N_CH-1:0]   req_ready,
    output logic [7:0]        enc_data,
    input  logic [15:0]       enc_ap,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CHW-1:0]    rsp_ch,
    output logic [15:0]       rsp_ap
);

    logic [CHW-1:0]  r_rr_ptr;
    logic [CHW-1:0]  r_tag_ch;
    logic            r_inflight;
    logic [CHW+15:0] r_mem [2];
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [1:0]      r_count;

    logic            w_found;
    logic [CHW-1:0]  w_gnt;
    logic [CHW-1:0]  w_idx;
    logic            w_ptr_hold;
    logic            w_pop;
    logic [2:0]      w_occ;
    logic            w_issue_ok;
    logic            w_accept;

    function automatic logic [CHW-1:0] f_wrap(input int v);
        return CHW'(v % N_CH);
    endfunction

    always_comb begin
        w_found    = 1'b0;
        w_gnt      = '0;
        w_idx      = '0;
        w_ptr_hold = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = f_wrap(int'(r_rr_ptr) + k);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
`ifdef AMP_ARB_PRIO_EN
        if (req_valid[0]) begin
            w_found    = 1'b1;
            w_gnt      = '0;
            w_ptr_hold = 1'b1;
        end
`endif
    end

    // Credit counts the in-flight sample and frees the slot being popped now.
    assign w_pop      = rsp_valid & rsp_ready;
    assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue_ok = rst_n & (w_occ < 3'd2);
    assign w_accept   = w_found & w_issue_ok;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            req_ready[i] = w_accept & (w_gnt == CHW'(i));
        end
    end

    assign enc_data = w_accept ? req_data[{w_gnt, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_tag_ch   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_tag_ch <= w_gnt;
                if (!w_ptr_hold) begin
                    r_rr_ptr <= f_wrap(int'(w_gnt) + 1);
                end
            end
        end
    end

    // A push into a full FIFO only happens alongside a pop, so it lands in the slot being freed.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wr_ptr] <= {r_tag_ch, enc_ap};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    assign rsp_valid        = (r_count != 2'd0);
    assign {rsp_ch, rsp_ap} = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_amp_arb.sv
// tb_amp_arb: directed scenarios plus a randomized run against a queue-based model.
// The shared encoder is modelled here as a registered thermometer lookup.
module tb_amp_arb;

    localparam int N_CH = 4;
    localparam int CHW  = 2;

    logic              clock = 1'b0;
    logic              rst_n;
    logic [N_CH-1:0]   req_valid;
    logic [N_CH*8-1:0] req_data;
    logic [N_CH-1:0]   req_ready;
    logic [7:0]        enc_data;
    logic [15:0]       enc_ap;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [CHW-1:0]    rsp_ch;
    logic [15:0]       rsp_ap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          ch;
        logic [15:0] ap;
        int          cyc;
    } ent_t;

    always #5 clock = ~clock;

    amp_arb #(.N_CH(N_CH), .CHW(CHW)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .enc_data  (enc_data),
        .enc_ap    (enc_ap),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ch    (rsp_ch),
        .rsp_ap    (rsp_ap)
    );

    function automatic logic [15:0] therm(input logic [7:0] x);
        int n;
        n = 0;
        for (int k = 1; k <= 16; k++) begin
            if (int'(x) >= ((k == 1) ? 1 : k * k - 1)) n++;
        end
        return 16'((32'hFFFF << (16 - n)) & 32'hFFFF);
    endfunction

    always @(posedge clock) enc_ap <= therm(enc_data);

    always @(posedge clock) begin
        if (rst_n && dut.r_inflight && dut.r_count == 2'd2 && !(rsp_valid && rsp_ready)) begin
            failures++;
            $display("FAIL overflow push into full fifo without pop");
        end
    end

    function automatic int seq_ch(input int k);
`ifdef AMP_ARB_PRIO_EN
        return 0 * k;
`else
        return k % N_CH;
`endif
    endfunction

    task automatic nxt;
        @(negedge clock);
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = {8'h11, 8'h22, 8'h33, 8'h44};
        rsp_ready = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
        end
        checks++;
        if (enc_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_enc_data got=%h exp=00", enc_data);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
        end
        checks++;
        if (rsp_ch !== 2'd0) begin
            failures++;
            $display("FAIL reset_rsp_ch got=%0d exp=0", rsp_ch);
        end
        checks++;
        if (rsp_ap !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rsp_ap got=%h exp=0000", rsp_ap);
        end
        @(negedge clock);
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    task automatic test_single;
        req_valid       = 4'b0100;
        req_data        = '0;
        req_data[23:16] = 8'h10;
        rsp_ready       = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_grant got=%b exp=0100", req_ready);
        end
        checks++;
        if (enc_data !== 8'h10) begin
            failures++;
            $display("FAIL single_enc_data got=%h exp=10", enc_data);
        end
        nxt;
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early_rsp got=%b exp=0", rsp_valid);
        end
        nxt;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd2 || rsp_ap !== 16'hF000) begin
            failures++;
            $display("FAIL single_rsp got=%b/%0d/%h exp=1/2/f000", rsp_valid, rsp_ch, rsp_ap);
        end
        for (int i = 0; i < 3; i++) begin
            nxt;
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_extra_rsp cycle=%0d got=%b exp=0", i, rsp_valid);
            end
        end
        nxt;
    endtask

    task automatic test_boundary;
        logic [7:0]  v [4];
        logic [15:0] a [4];
        v = '{8'h00, 8'hFF, 8'hF1, 8'hC8};
        a = '{16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFC};
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_data = '0;
            if (i < 4) begin
                req_valid     = 4'b0001;
                req_data[7:0] = v[i];
            end else begin
                req_valid = '0;
            end
            #1;
            if (i < 4) begin
                checks++;
                if (req_ready !== 4'b0001) begin
                    failures++;
                    $display("FAIL bound_grant i=%0d got=%b exp=0001", i, req_ready);
                end
            end
            if (i >= 2 && i < 6) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_ch !== 2'd0 || rsp_ap !== a[i-2]) begin
                    failures++;
                    $display("FAIL bound_rsp i=%0d got=%b/%0d/%h exp=1/0/%h",
                             i, rsp_valid, rsp_ch, rsp_ap, a[i-2]);
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL bound_idle i=%0d got=%b exp=0", i, rsp_valid);
                end
            end
            nxt;
        end
    endtask

    task automatic test_rotation;
        logic [7:0] d [N_CH];
        int         c;
        do_reset;
        for (int j = 0; j < N_CH; j++) begin
            d[j]             = 8'($urandom);
            req_data[8*j+:8] = d[j];
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << seq_ch(i))) begin
                failures++;
                $display("FAIL rot_grant i=%0d got=%b exp=%b", i, req_ready, 4'(1 << seq_ch(i)));
            end
            if (i >= 2) begin
                c = seq_ch(i - 2);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_ch !== 2'(c) || rsp_ap !== therm(d[c])) begin
                    failures++;
                    $display("FAIL rot_rsp i=%0d got=%b/%0d/%h exp=1/%0d/%h",
                             i, rsp_valid, rsp_ch, rsp_ap, c, therm(d[c]));
                end
            end
            nxt;
        end
        req_valid = '0;
        repeat (3) nxt;
    endtask

    task automatic test_backpressure;
        logic [7:0] d [N_CH];
        int         acc;
        int         c;
        do_reset;
        for (int j = 0; j < N_CH; j++) begin
            d[j]             = 8'($urandom);
            req_data[8*j+:8] = d[j];
        end
        req_valid = '1;
        rsp_ready = 1'b0;
        acc       = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) rsp_ready = 1'b1;
            #1;
            if (i < 8 && req_ready !== 4'b0000) acc++;
            if (i < 2) begin
                checks++;
                if (req_ready !== 4'(1 << seq_ch(i))) begin
                    failures++;
                    $display("FAIL bp_grant i=%0d got=%b exp=%b", i, req_ready, 4'(1 << seq_ch(i)));
                end
            end else if (i < 8) begin
                c = seq_ch(0);
                checks++;
                if (req_ready !== 4'b0000) begin
                    failures++;
                    $display("FAIL bp_stall_ready i=%0d got=%b exp=0000", i, req_ready);
                end
                checks++;
                if (rsp_valid !== 1'b1 || rsp_ch !== 2'(c) || rsp_ap !== therm(d[c])) begin
                    failures++;
                    $display("FAIL bp_hold i=%0d got=%b/%0d/%h exp=1/%0d/%h",
                             i, rsp_valid, rsp_ch, rsp_ap, c, therm(d[c]));
                end
            end else begin
                checks++;
                if (req_ready !== 4'(1 << seq_ch(i - 6))) begin
                    failures++;
                    $display("FAIL bp_resume i=%0d got=%b exp=%b", i, req_ready, 4'(1 << seq_ch(i - 6)));
                end
                c = seq_ch(i - 8);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_ch !== 2'(c) || rsp_ap !== therm(d[c])) begin
                    failures++;
                    $display("FAIL bp_drain i=%0d got=%b/%0d/%h exp=1/%0d/%h",
                             i, rsp_valid, rsp_ch, rsp_ap, c, therm(d[c]));
                end
            end
            nxt;
        end
        checks++;
        if (acc != 2) begin
            failures++;
            $display("FAIL bp_accept_count got=%0d exp=2", acc);
        end
        req_valid = '0;
        repeat (3) nxt;
    endtask

    task automatic test_reset_midflight;
        do_reset;
        req_valid       = 4'b0010;
        req_data[15:8]  = 8'h5A;
        rsp_ready       = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_grant got=%b exp=0010", req_ready);
        end
        nxt;
        req_valid = '0;
        #2;
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_reset got=%b/%b exp=0000/0", req_ready, rsp_valid);
        end
        nxt;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_hold got=%b exp=0", rsp_valid);
        end
        nxt;
        rst_n     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_ghost_rsp i=%0d got=%b exp=0", i, rsp_valid);
            end
            nxt;
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_first_grant got=%b exp=0001", req_ready);
        end
        nxt;
        req_valid = '0;
        repeat (3) nxt;
    endtask

    task automatic test_random;
        ent_t       q [$];
        ent_t       e;
        int         ptr;
        int         cyc;
        int         g;
        bit         vis;
        bit         pop;
        bit         ok;
        bit         acc;
        logic [3:0] exp_rr;
        logic [7:0] exp_enc;
        do_reset;
        ptr = 0;
        cyc = 0;
        for (int c = 0; c < 600; c++) begin
            req_valid = 4'($urandom);
            req_data  = $urandom;
            if ((c / 50) % 2 == 0) rsp_ready = ($urandom_range(0, 3) == 0);
            else                   rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            vis = (q.size() > 0) && (q[0].cyc <= cyc - 2);
            pop = vis && rsp_ready;
            ok  = (q.size() - (pop ? 1 : 0)) < 2;
            g   = -1;
            for (int k = 0; k < N_CH; k++) begin
                if (g < 0 && req_valid[(ptr + k) % N_CH]) g = (ptr + k) % N_CH;
            end
`ifdef AMP_ARB_PRIO_EN
            if (req_valid[0]) g = 0;
`endif
            acc     = ok && (g >= 0);
            exp_rr  = acc ? 4'(1 << g) : 4'b0000;
            exp_enc = acc ? req_data[8*g+:8] : 8'h00;
            checks++;
            if (req_ready !== exp_rr) begin
                failures++;
                $display("FAIL rnd_req_ready c=%0d got=%b exp=%b", c, req_ready, exp_rr);
            end
            checks++;
            if (enc_data !== exp_enc) begin
                failures++;
                $display("FAIL rnd_enc_data c=%0d got=%h exp=%h", c, enc_data, exp_enc);
            end
            checks++;
            if (rsp_valid !== vis) begin
                failures++;
                $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, vis);
            end
            if (vis) begin
                checks++;
                if (rsp_ch !== 2'(q[0].ch) || rsp_ap !== q[0].ap) begin
                    failures++;
                    $display("FAIL rnd_rsp_data c=%0d got=%0d/%h exp=%0d/%h",
                             c, rsp_ch, rsp_ap, q[0].ch, q[0].ap);
                end
            end
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.ch  = g;
                e.ap  = therm(req_data[8*g+:8]);
                e.cyc = cyc;
                q.push_back(e);
`ifdef AMP_ARB_PRIO_EN
                if (!req_valid[0]) ptr = (g + 1) % N_CH;
`else
                ptr = (g + 1) % N_CH;
`endif
            end
            cyc++;
            nxt;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) nxt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        test_reset;
        test_single;
        test_boundary;
        test_rotation;
        test_backpressure;
        test_reset_midflight;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
